// File: rtl/game_pkg.sv
// Shared game definitions: missile FSM encoding, screen geometry, x-clamp helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package game_pkg;

  localparam int H_ACTIVE = 800;  // visible pixels per line
  localparam int V_ACTIVE = 600;  // visible lines per frame

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLYING   = 2'd1,
    ST_COOLDOWN = 2'd2
  } missile_state_t;

  // Limit a 12-bit x so the whole sprite stays on screen. The sum is kept at
  // 12 bits by the caller so a large player x cannot wrap below the limit.
  function automatic logic [10:0] clamp_x(input logic [11:0] x, input logic [11:0] x_max);
    logic [11:0] r;
    r = (x > x_max) ? x_max : x;
    return r[10:0];
  endfunction

endpackage

// File: rtl/missile_draw.sv
// Sprite overlay stage: paints a solid rectangle over the VGA stream.
// Latency: exactly 1 pclk for colour and all timing signals.
// Backpressure: none; free-running pixel stream, one pixel per cycle.
// Ports: pclk/rst; vcount/vsync/vblnk/hcount/hsync/hblnk/rgb _in -> _out;
//        xpos/ypos = sprite top-left, on_sprite = sprite visible.
module missile_draw #(
  parameter int          SPRITE_W     = 4,
  parameter int          SPRITE_H     = 12,
  parameter logic [11:0] SPRITE_COLOR = 12'hFF0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        on_sprite,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out
);

  // Bounds are widened to 12 bits so x+W / y+H never wrap at the screen edge.
  logic [11:0] x_lo, x_hi, y_lo, y_hi, hc, vc;
  logic        hit;

  always_comb begin
    hc   = {1'b0, hcount_in};
    vc   = {1'b0, vcount_in};
    x_lo = {1'b0, xpos};
    y_lo = {1'b0, ypos};
    x_hi = x_lo + 12'(SPRITE_W);
    y_hi = y_lo + 12'(SPRITE_H);
    hit  = on_sprite & ~hblnk_in & ~vblnk_in
         & (hc >= x_lo) & (hc < x_hi)
         & (vc >= y_lo) & (vc < y_hi);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      vcount_out <= '0;
      vsync_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      hcount_out <= '0;
      hsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      vcount_out <= vcount_in;
      vsync_out  <= vsync_in;
      vblnk_out  <= vblnk_in;
      hcount_out <= hcount_in;
      hsync_out  <= hsync_in;
      hblnk_out  <= hblnk_in;
      rgb_out    <= hit ? SPRITE_COLOR : rgb_in;
    end
  end

endmodule

// File: rtl/missile_ctl.sv
// Player missile: launch on fire, climb SPEED px per frame, cooldown, overlay on VGA.
// Latency: video 1 pclk; position/state change only on the vblank rising edge.
// Backpressure: none; free-running pixel stream. Fire presses outside IDLE are dropped.
// Ports: pclk, rst (sync, active high), fire, xpos_player; VGA timing+rgb in/out;
//        xpos_missile, ypos_missile, on_missle feed the downstream collision logic.
// Build option: MISSILE_AUTOFIRE_EN -- fire level (not just edge) arms a launch in IDLE.
module missile_ctl
  import game_pkg::*;
#(
  parameter int          MISSILE_W       = 4,
  parameter int          MISSILE_H       = 12,
  parameter int          SPEED           = 8,
  parameter int          Y_START         = 540,
  parameter int          Y_TOP           = 0,
  parameter int          X_OFFSET        = 22,
  parameter int          COOLDOWN_FRAMES = 10,
  parameter logic [11:0] MISSILE_COLOR   = 12'hFF0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        fire,
  input  logic [10:0] xpos_player,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [11:0] rgb_out,
  output logic [10:0] xpos_missile,
  output logic [10:0] ypos_missile,
  output logic        on_missle
);

  localparam int          CD_W  = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [11:0] X_MAX = 12'(H_ACTIVE - MISSILE_W);

  missile_state_t state, state_nxt;
  logic            fire_q, vblnk_q, pending;
  logic [CD_W-1:0] cd_cnt;
  logic            tick, fire_set, at_top, cd_last, launch;
  logic [11:0]     x_launch;

  assign tick     = vblnk_in & ~vblnk_q;
  assign x_launch = {1'b0, xpos_player} + 12'(X_OFFSET);
  // Compare before subtracting so ypos can never wrap below zero.
  assign at_top   = {1'b0, ypos_missile} < 12'(Y_TOP + SPEED);
  assign cd_last  = cd_cnt == CD_W'(COOLDOWN_FRAMES - 1);
  // pending is the registered value, so a press on a tick cycle waits one frame.
  assign launch   = tick & (state == ST_IDLE) & pending;

`ifdef MISSILE_AUTOFIRE_EN
  assign fire_set = fire;
`else
  assign fire_set = fire & ~fire_q;
`endif

  // State register
  always_ff @(posedge pclk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: every transition waits for a frame tick
  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        ST_IDLE:     if (pending) state_nxt = ST_FLYING;
        ST_FLYING:   if (at_top)  state_nxt = ST_COOLDOWN;
        ST_COOLDOWN: if (cd_last) state_nxt = ST_IDLE;
        default:                  state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    on_missle = (state == ST_FLYING);
  end

  // Edge detectors, launch request, cooldown counter and position registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      fire_q       <= 1'b0;
      vblnk_q      <= 1'b0;
      pending      <= 1'b0;
      cd_cnt       <= '0;
      xpos_missile <= '0;
      ypos_missile <= '0;
    end else begin
      fire_q  <= fire;
      vblnk_q <= vblnk_in;

      if (launch)
        pending <= 1'b0;
      else if ((state == ST_IDLE) && fire_set)
        pending <= 1'b1;

      if (launch) begin
        xpos_missile <= clamp_x(x_launch, X_MAX);
        ypos_missile <= 11'(Y_START);
      end else if (tick && (state == ST_FLYING) && !at_top) begin
        ypos_missile <= ypos_missile - 11'(SPEED);
      end

      if (tick && (state == ST_COOLDOWN))
        cd_cnt <= cd_last ? '0 : cd_cnt + 1'b1;
    end
  end

  missile_draw #(
    .SPRITE_W    (MISSILE_W),
    .SPRITE_H    (MISSILE_H),
    .SPRITE_COLOR(MISSILE_COLOR)
  ) u_draw (
    .pclk      (pclk),
    .rst       (rst),
    .vcount_in (vcount_in),
    .vsync_in  (vsync_in),
    .vblnk_in  (vblnk_in),
    .hcount_in (hcount_in),
    .hsync_in  (hsync_in),
    .hblnk_in  (hblnk_in),
    .rgb_in    (rgb_in),
    .xpos      (xpos_missile),
    .ypos      (ypos_missile),
    .on_sprite (on_missle),
    .vcount_out(vcount_out),
    .vsync_out (vsync_out),
    .vblnk_out (vblnk_out),
    .hcount_out(hcount_out),
    .hsync_out (hsync_out),
    .hblnk_out (hblnk_out),
    .rgb_out   (rgb_out)
  );

endmodule

// File: tb/tb_missile_ctl.sv
// Bench for missile_ctl: directed stimulus pushes expectations tagged with the
// cycle they fall due; an independent negedge monitor pops and compares.
module tb_missile_ctl;

  logic        pclk = 1'b0;
  logic        rst, fire;
  logic [10:0] xpos_player, vcount_in, hcount_in;
  logic        vsync_in, vblnk_in, hsync_in, hblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] vcount_out, hcount_out, xpos_missile, ypos_missile;
  logic        vsync_out, vblnk_out, hsync_out, hblnk_out, on_missle;
  logic [11:0] rgb_out;

  always #5 pclk = ~pclk;

  missile_ctl dut (
    .pclk(pclk), .rst(rst), .fire(fire), .xpos_player(xpos_player),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in), .rgb_in(rgb_in),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out), .rgb_out(rgb_out),
    .xpos_missile(xpos_missile), .ypos_missile(ypos_missile), .on_missle(on_missle)
  );

  // sel: 0 on_missle, 1 xpos, 2 ypos, 3 rgb_out, 4 hcount_out, 5 vcount_out,
  //      6 {hsync,hblnk,vsync,vblnk}_out
  typedef struct {
    int    cyc;
    string name;
    int    sel;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  function automatic int actual(input int sel);
    case (sel)
      0:       return int'(on_missle);
      1:       return int'(xpos_missile);
      2:       return int'(ypos_missile);
      3:       return int'(rgb_out);
      4:       return int'(hcount_out);
      5:       return int'(vcount_out);
      default: return int'({hsync_out, hblnk_out, vsync_out, vblnk_out});
    endcase
  endfunction

  exp_t m_e;
  int   m_act;
  always @(negedge pclk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e   = sb.pop_front();
      m_act = actual(m_e.sel);
      n_total++;
      if (m_e.cyc != cyc)
        $display("FAIL %s: check missed, due cycle %0d, now %0d", m_e.name, m_e.cyc, cyc);
      else if (m_act == m_e.val)
        n_pass++;
      else
        $display("FAIL %s: actual 0x%0h required 0x%0h", m_e.name, m_act, m_e.val);
    end
  end

  task automatic expect_v(input int d, input string name, input int sel, input int val);
    exp_t e;
    e.cyc = cyc + d; e.name = name; e.sel = sel; e.val = val;
    sb.push_back(e);
  endtask

  task automatic cyc1();
    @(posedge pclk); #1;
  endtask

  // One frame tick: a single-cycle vblank rising edge.
  task automatic tick();
    vblnk_in = 1'b1; cyc1();
    vblnk_in = 1'b0; cyc1();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_fire();
    fire = 1'b1; cyc1();
    fire = 1'b0; cyc1();
  endtask

  task automatic reset_pulse();
    rst = 1'b1; cyc1();
    rst = 1'b0; cyc1();
  endtask

  // Current missile state; x < 0 skips the position checks.
  task automatic chk(input string name, input int on, input int x, input int y);
    expect_v(0, {name, "_on"}, 0, on);
    if (x >= 0) begin
      expect_v(0, {name, "_x"}, 1, x);
      expect_v(0, {name, "_y"}, 2, y);
    end
  endtask

  // Drive one active-video pixel and expect its colour one cycle later.
  task automatic pixel(input string name, input int h, input int v, input bit hb,
                       input int rgb, input int exp_rgb);
    hcount_in = 11'(h); vcount_in = 11'(v); hblnk_in = hb; vblnk_in = 1'b0;
    rgb_in = 12'(rgb);
    expect_v(1, name, 3, exp_rgb);
    cyc1();
  endtask

  initial begin
    rst = 1'b1; fire = 1'b0; xpos_player = '0;
    hcount_in = 11'd123; vcount_in = 11'd45; rgb_in = 12'hABC;
    hsync_in = 1'b1; hblnk_in = 1'b1; vsync_in = 1'b1; vblnk_in = 1'b0;
    repeat (3) cyc1();

    // Reset state: everything zero even though inputs are busy
    chk("reset", 0, 0, 0);
    expect_v(0, "reset_rgb", 3, 0);
    expect_v(0, "reset_hcount", 4, 0);
    expect_v(0, "reset_sync", 6, 0);

    // Timing and colour pass straight through one cycle late
    rst = 1'b0;
    hcount_in = 11'd123; vcount_in = 11'd45; rgb_in = 12'h5A5;
    hsync_in = 1'b1; hblnk_in = 1'b0; vsync_in = 1'b0;
    expect_v(1, "pass1_h", 4, 123);
    expect_v(1, "pass1_v", 5, 45);
    expect_v(1, "pass1_rgb", 3, 'h5A5);
    expect_v(1, "pass1_sync", 6, 'b1000);
    cyc1();
    hcount_in = 11'd799; vcount_in = 11'd599; rgb_in = 12'h0F0;
    hsync_in = 1'b0; hblnk_in = 1'b1; vsync_in = 1'b1;
    expect_v(1, "pass2_h", 4, 799);
    expect_v(1, "pass2_v", 5, 599);
    expect_v(1, "pass2_rgb", 3, 'h0F0);
    expect_v(1, "pass2_sync", 6, 'b0110);
    cyc1();
    hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0;
    ticks(3);
    chk("idle3", 0, -1, 0);
    pixel("idle_pix", 322, 540, 1'b0, 'h00F, 'h00F);

    // Launch from x=300
    xpos_player = 11'd300;
    pulse_fire();
    chk("armed_no_tick", 0, -1, 0);
    tick();
    chk("launch", 1, 322, 540);
    pixel("hit_tl", 322, 540, 1'b0, 'h00F, 'hFF0);
    pixel("hit_br", 325, 551, 1'b0, 'h00F, 'hFF0);
    pixel("miss_right", 326, 540, 1'b0, 'h00F, 'h00F);
    pixel("miss_left", 321, 540, 1'b0, 'h00F, 'h00F);
    pixel("miss_above", 322, 539, 1'b0, 'h00F, 'h00F);
    pixel("miss_below", 322, 552, 1'b0, 'h00F, 'h00F);
    pixel("miss_hblank", 323, 545, 1'b1, 'h00F, 'h00F);
    tick();
    chk("step1", 1, 322, 532);

    // Flight to the top, then cooldown that drops fire presses
    ticks(66);
    chk("near_top", 1, 322, 4);
    pulse_fire();
    tick();
    chk("end_flight", 0, 322, 4);
    pixel("no_draw_cd", 322, 4, 1'b0, 'h123, 'h123);
    for (int i = 0; i < 10; i++) begin
      pulse_fire();
      tick();
      chk("cooldown", 0, -1, 0);
    end
    tick();
    chk("idle_not_queued", 0, -1, 0);
    pulse_fire();
    tick();
    chk("relaunch", 1, 322, 540);

    // Reset mid-flight kills the missile
    ticks(30);
    chk("mid_flight", 1, 322, 300);
    rst = 1'b1;
    expect_v(1, "rst_kill_on", 0, 0);
    expect_v(1, "rst_kill_y", 2, 0);
    expect_v(1, "rst_kill_rgb", 3, 0);
    cyc1();
    rst = 1'b0; cyc1();
    tick();
    chk("post_rst_idle", 0, -1, 0);
    pulse_fire();
    tick();
    chk("post_rst_launch", 1, 322, 540);

    // Right-edge clamp
    reset_pulse();
    xpos_player = 11'd790;
    pulse_fire();
    tick();
    chk("clamp790", 1, 796, 540);
    pixel("edge_799", 799, 545, 1'b0, 'h00F, 'hFF0);
    pixel("edge_800", 800, 545, 1'b0, 'h00F, 'h00F);
    pixel("edge_796", 796, 540, 1'b0, 'h00F, 'hFF0);
    pixel("edge_795", 795, 540, 1'b0, 'h00F, 'h00F);
    reset_pulse();
    xpos_player = 11'd2047;
    pulse_fire();
    tick();
    chk("clamp2047", 1, 796, 540);
    reset_pulse();
    xpos_player = 11'd774;
    pulse_fire();
    tick();
    chk("exact774", 1, 796, 540);

    // Press on the tick cycle itself launches one frame later
    reset_pulse();
    xpos_player = 11'd100;
    fire = 1'b1; vblnk_in = 1'b1; cyc1();
    fire = 1'b0; vblnk_in = 1'b0; cyc1();
    chk("same_cycle_wait", 0, -1, 0);
    tick();
    chk("same_cycle_launch", 1, 122, 540);

    // Fire held high across more than a full flight + cooldown
    reset_pulse();
    fire = 1'b1; cyc1();
    tick();
    chk("hold_launch", 1, 122, 540);
    ticks(84);
`ifdef MISSILE_AUTOFIRE_EN
    chk("hold_relaunch", 1, -1, 0);
`else
    chk("hold_single", 0, -1, 0);
`endif
    fire = 1'b0;

    cyc1(); cyc1();
    if (sb.size() != 0) begin
      n_total += sb.size();
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
